// File: rtl/vga_rect_fill.sv
`default_nettype none
// ============================================================================
//  Module      : vga_rect_fill
//  Description : Wishbone initiator that fills a screen-clipped, axis-aligned
//                rectangle of the VGA framebuffer with a single colour, one
//                single-beat write per pixel, row-major order.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_rect_fill #(
   parameter int          VGA_WIDTH       = 640,
   parameter int          VGA_HEIGHT      = 480,
   parameter int          VGA_COLOR_DEPTH = 8,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int          ACK_TIMEOUT     = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [9:0]                   cmd_x,
   input  logic [8:0]                   cmd_y,
   input  logic [9:0]                   cmd_w,
   input  logic [9:0]                   cmd_h,
   input  logic [3*VGA_COLOR_DEPTH-1:0] cmd_color,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic                         cyc_o,
   output logic                         stb_o,
   output logic                         we_o,
   output logic [3:0]                   sel_o,
   output logic [31:0]                  addr_o,
   output logic [31:0]                  data_o,
   input  logic                         ack_i
);

   localparam int          C_CW        = 3 * VGA_COLOR_DEPTH;
   localparam int          C_TW        = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam logic [10:0] C_W11       = 11'(VGA_WIDTH);
   localparam logic [10:0] C_H11       = 11'(VGA_HEIGHT);
   localparam logic [31:0] C_ROW_BYTES = 32'(4 * VGA_WIDTH);
   localparam logic [C_TW-1:0] C_TLAST = C_TW'(ACK_TIMEOUT - 1);

   // Packed colour must fit in one 32-bit data word.
   generate
      if (C_CW > 32) begin : g_bad_color_depth
         $error("vga_rect_fill: 3*VGA_COLOR_DEPTH must not exceed 32");
      end
      if (ACK_TIMEOUT < 1) begin : g_bad_timeout
         $error("vga_rect_fill: ACK_TIMEOUT must be at least 1");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLIP  = 3'd1,
      S_WRITE = 3'd2,
      S_NEXT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [9:0]        r_x;
   logic [8:0]        r_y;
   logic [9:0]        r_w;
   logic [9:0]        r_h;
   logic [C_CW-1:0]   r_color;
   logic [9:0]        r_cx;
   logic [8:0]        r_cy;
   logic [9:0]        r_x_last;
   logic [8:0]        r_y_last;
   logic [31:0]       r_row_addr;
   logic [C_TW-1:0]   r_tcnt;
   logic              r_err;

   logic              w_accept;
   logic [10:0]       w_x_end;
   logic [10:0]       w_y_end;
   logic [10:0]       w_x_lim;
   logic [10:0]       w_y_lim;
   logic [9:0]        w_x_last;
   logic [8:0]        w_y_last;
   logic              w_degenerate;
   logic [31:0]       w_start_addr;
   logic              w_row_end;
   logic              w_last;
   logic              w_timeout;

   // Clip arithmetic is done in 11 bits so x+w and y+h never wrap.
   assign w_x_end      = {1'b0, r_x} + {1'b0, r_w};
   assign w_y_end      = {2'b00, r_y} + {1'b0, r_h};
   assign w_x_lim      = (w_x_end > C_W11) ? C_W11 : w_x_end;
   assign w_y_lim      = (w_y_end > C_H11) ? C_H11 : w_y_end;
   assign w_x_last     = 10'(w_x_lim - 11'd1);
   assign w_y_last     = 9'(w_y_lim - 11'd1);
   assign w_degenerate = ({1'b0, r_x} >= C_W11) || ({2'b00, r_y} >= C_H11) ||
                         (r_w == 10'd0) || (r_h == 10'd0);
   assign w_start_addr = BASE_ADDR + ((32'(r_y) * 32'(VGA_WIDTH) + 32'(r_x)) << 2);

   assign w_accept  = cmd_valid && cmd_ready;
   assign w_row_end = (r_cx == r_x_last);
   assign w_last    = w_row_end && (r_cy == r_y_last);
   assign w_timeout = (r_tcnt == C_TLAST);
   assign err       = r_err;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and Wishbone/handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      cmd_ready   = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      cyc_o       = 1'b0;
      stb_o       = 1'b0;
      we_o        = 1'b0;
      sel_o       = 4'h0;
      case (r_state)
         S_IDLE: begin
            busy      = 1'b0;
            cmd_ready = !rst;
            if (w_accept) begin
               w_state_nxt = S_CLIP;
            end
         end
         S_CLIP: begin
            w_state_nxt = w_degenerate ? S_DONE : S_WRITE;
         end
         S_WRITE: begin
            cyc_o = 1'b1;
            stb_o = 1'b1;
            we_o  = 1'b1;
            sel_o = 4'hF;
            if (ack_i) begin
               w_state_nxt = S_NEXT;
            end else if (w_timeout) begin
               w_state_nxt = S_DONE;
            end
         end
         S_NEXT: begin
            w_state_nxt = w_last ? S_DONE : S_WRITE;
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Command latch, pixel walker, bus address/data and timeout bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x        <= '0;
         r_y        <= '0;
         r_w        <= '0;
         r_h        <= '0;
         r_color    <= '0;
         r_cx       <= '0;
         r_cy       <= '0;
         r_x_last   <= '0;
         r_y_last   <= '0;
         r_row_addr <= '0;
         r_tcnt     <= '0;
         r_err      <= 1'b0;
         addr_o     <= '0;
         data_o     <= '0;
      end else begin
         if (w_accept) begin
            r_x     <= cmd_x;
            r_y     <= cmd_y;
            r_w     <= cmd_w;
            r_h     <= cmd_h;
            r_color <= cmd_color;
            r_err   <= 1'b0;
         end
         case (r_state)
            S_CLIP: begin
               r_tcnt <= '0;
               if (!w_degenerate) begin
                  r_cx       <= r_x;
                  r_cy       <= r_y;
                  r_x_last   <= w_x_last;
                  r_y_last   <= w_y_last;
                  r_row_addr <= w_start_addr;
                  addr_o     <= w_start_addr;
                  data_o     <= 32'(r_color);
               end
            end
            S_WRITE: begin
               r_tcnt <= r_tcnt + C_TW'(1);
               if (!ack_i && w_timeout) begin
                  r_err <= 1'b1;
               end
            end
            S_NEXT: begin
               r_tcnt <= '0;
               if (!w_last) begin
                  if (w_row_end) begin
                     r_cx       <= r_x;
                     r_cy       <= r_cy + 9'd1;
                     r_row_addr <= r_row_addr + C_ROW_BYTES;
                     addr_o     <= r_row_addr + C_ROW_BYTES;
                  end else begin
                     r_cx   <= r_cx + 10'd1;
                     addr_o <= addr_o + 32'd4;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_fill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_rect_fill
//  Description : Self-checking bench for vga_rect_fill with a behavioural
//                rectangle model and a Wishbone slave with programmable
//                ack latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_rect_fill;

   localparam int C_W  = 640;
   localparam int C_H  = 480;
   localparam int C_TO = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_x;
   logic [8:0]  cmd_y;
   logic [9:0]  cmd_w;
   logic [9:0]  cmd_h;
   logic [23:0] cmd_color;
   logic        busy, done, err, cyc_o, stb_o, we_o, ack_i;
   logic [3:0]  sel_o;
   logic [31:0] addr_o, data_o;

   vga_rect_fill #(
      .VGA_WIDTH      (C_W),
      .VGA_HEIGHT     (C_H),
      .VGA_COLOR_DEPTH(8),
      .BASE_ADDR      (32'h0000_0000),
      .ACK_TIMEOUT    (C_TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_x    (cmd_x),
      .cmd_y    (cmd_y),
      .cmd_w    (cmd_w),
      .cmd_h    (cmd_h),
      .cmd_color(cmd_color),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .cyc_o    (cyc_o),
      .stb_o    (stb_o),
      .we_o     (we_o),
      .sel_o    (sel_o),
      .addr_o   (addr_o),
      .data_o   (data_o),
      .ack_i    (ack_i)
   );

   always #5 clk = ~clk;

   // Slave: acks after ack_delay wait states; delay 0 is a combinational ack.
   int  ack_delay = 1;
   bit  never_ack = 1'b0;
   int  wait_cnt  = 0;
   assign ack_i = stb_o && !never_ack && (wait_cnt >= ack_delay);

   // Wait-state counter for the slave.
   always @(posedge clk) begin
      if (stb_o && !ack_i) wait_cnt <= wait_cnt + 1;
      else                 wait_cnt <= 0;
   end

   longint cycle = 0;
   // Free-running cycle counter.
   always @(posedge clk) cycle <= cycle + 1;

   // Bus monitor: collects completed writes and protocol statistics.
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int     n_done = 0, n_cyc = 0, n_stb = 0, n_unstable = 0, n_badsel = 0;
   longint done_cycle = 0;
   logic   p_stb = 1'b0, p_ack = 1'b0;
   logic [31:0] p_addr = '0, p_data = '0;
   always @(negedge clk) begin
      if (stb_o && ack_i) begin
         wr_addr_q.push_back(addr_o);
         wr_data_q.push_back(data_o);
      end
      if (done) begin
         n_done++;
         done_cycle = cycle;
      end
      if (cyc_o) n_cyc++;
      if (stb_o) n_stb++;
      if (stb_o && (sel_o != 4'hF || !we_o || !cyc_o)) n_badsel++;
      if (stb_o && p_stb && !p_ack && (addr_o != p_addr || data_o != p_data)) n_unstable++;
      p_stb  = stb_o;
      p_ack  = ack_i;
      p_addr = addr_o;
      p_data = data_o;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Reference: list of pixel byte addresses a clipped rectangle covers.
   logic [31:0] exp_q[$];
   task automatic model(input int x, input int y, input int w, input int h);
      exp_q.delete();
      if (x >= C_W || y >= C_H || w == 0 || h == 0) return;
      for (int r = y; r < y + h && r < C_H; r++)
         for (int c = x; c < x + w && c < C_W; c++)
            exp_q.push_back(32'(4 * (r * C_W + c)));
   endtask

   int last_base;

   task automatic run_cmd(input int x, input int y, input int w, input int h,
                          input logic [23:0] color, input bit exp_to);
      int     base_q, base_done, base_cyc, base_stb, t, n;
      longint acc;
      base_q    = wr_addr_q.size();
      base_done = n_done;
      base_cyc  = n_cyc;
      base_stb  = n_stb;
      last_base = base_q;
      t = 0;
      while (!cmd_ready && t < 100) begin
         tick();
         t++;
      end
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_x     = 10'(x);
      cmd_y     = 9'(y);
      cmd_w     = 10'(w);
      cmd_h     = 10'(h);
      cmd_color = color;
      cmd_valid = 1'b1;
      acc       = cycle;
      tick();
      cmd_valid = 1'b0;
      t = 0;
      while (n_done == base_done && t < 5000) begin
         tick();
         t++;
      end
      chk("done_seen", n_done - base_done, 1);
      tick();
      chk("busy_after_done", busy, 0);
      chk("done_once", n_done - base_done, 1);
      chk("err", err, exp_to);
      model(x, y, w, h);
      n = exp_to ? 0 : exp_q.size();
      chk("n_writes", wr_addr_q.size() - base_q, n);
      for (int i = 0; i < n && base_q + i < wr_addr_q.size(); i++) begin
         chk("wr_addr", wr_addr_q[base_q + i], exp_q[i]);
         chk("wr_data", wr_data_q[base_q + i], {8'h00, color});
      end
      if (exp_to) begin
         chk("timeout_stb_cycles", n_stb - base_stb, C_TO);
      end else begin
         chk("latency", done_cycle - acc, 2 + n * (ack_delay + 2));
         chk("stb_cycles", n_stb - base_stb, n * (ack_delay + 1));
         if (n == 0) chk("no_cyc", n_cyc - base_cyc, 0);
      end
   endtask

   // Hard time limit so the run always terminates.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, base_done, t;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_x     = '0;
      cmd_y     = '0;
      cmd_w     = '0;
      cmd_h     = '0;
      cmd_color = '0;
      repeat (3) tick();
      chk("rst_cyc", cyc_o, 0);
      chk("rst_stb", stb_o, 0);
      chk("rst_we", we_o, 0);
      chk("rst_sel", sel_o, 0);
      chk("rst_addr", addr_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", cmd_ready, 0);
      rst = 1'b0;
      tick();
      chk("ready_after_rst", cmd_ready, 1);

      // Basic fill, ack one cycle after strobe.
      ack_delay = 1;
      run_cmd(10, 5, 2, 2, 24'hFF0000, 0);
      chk("t1_a0", wr_addr_q[last_base + 0], 32'h3228);
      chk("t1_a1", wr_addr_q[last_base + 1], 32'h322C);
      chk("t1_a2", wr_addr_q[last_base + 2], 32'h3C28);
      chk("t1_a3", wr_addr_q[last_base + 3], 32'h3C2C);
      chk("t1_d0", wr_data_q[last_base + 0], 32'h00FF0000);

      // Clipping at the bottom-right corner.
      run_cmd(638, 479, 5, 5, 24'h00FF00, 0);
      chk("t2_a0", wr_addr_q[last_base + 0], 32'h12BFF8);
      chk("t2_a1", wr_addr_q[last_base + 1], 32'h12BFFC);

      // Degenerate commands.
      run_cmd(640, 0, 4, 4, 24'h123456, 0);
      run_cmd(3, 3, 0, 4, 24'h123456, 0);
      run_cmd(3, 3, 4, 0, 24'h123456, 0);

      // Wait states and zero-latency slave.
      ack_delay = 3;
      run_cmd(20, 30, 3, 1, 24'h0000FF, 0);
      ack_delay = 0;
      run_cmd(100, 200, 3, 2, 24'hA5A5A5, 0);

      // Ack timeout, then recovery clears err.
      never_ack = 1'b1;
      run_cmd(0, 0, 1, 1, 24'hABCDEF, 1);
      never_ack = 1'b0;
      ack_delay = 1;
      run_cmd(1, 1, 1, 1, 24'h010203, 0);

      // Randomized commands, biased towards the screen edges.
      for (int k = 0; k < 30; k++) begin
         int x, y;
         if ($urandom_range(0, 2) == 0) begin
            x = $urandom_range(C_W - 4, C_W + 2);
            y = $urandom_range(C_H - 4, C_H + 2);
         end else begin
            x = $urandom_range(0, C_W - 1);
            y = $urandom_range(0, C_H - 1);
         end
         ack_delay = $urandom_range(0, 3);
         run_cmd(x, y, $urandom_range(0, 5), $urandom_range(0, 5),
                 24'($urandom), 0);
      end

      // Reset in the middle of a 4x4 fill, after the second ack.
      ack_delay = 1;
      base = wr_addr_q.size();
      t = 0;
      while (!cmd_ready && t < 100) begin
         tick();
         t++;
      end
      cmd_x = 10'd50; cmd_y = 9'd60; cmd_w = 10'd4; cmd_h = 10'd4;
      cmd_color = 24'h777777;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      t = 0;
      while (wr_addr_q.size() - base < 2 && t < 200) begin
         tick();
         t++;
      end
      chk("rst_mid_two_writes", wr_addr_q.size() - base, 2);
      rst = 1'b1;
      tick();
      chk("rst_mid_cyc", cyc_o, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_ready_low", cmd_ready, 0);
      rst = 1'b0;
      base_done = n_done;
      tick();
      chk("rst_mid_ready", cmd_ready, 1);
      repeat (20) tick();
      chk("rst_mid_no_more_writes", wr_addr_q.size() - base, 2);
      chk("rst_mid_no_done", n_done - base_done, 0);

      chk("stable_during_wait", n_unstable, 0);
      chk("sel_we_cyc_with_stb", n_badsel, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_rect_fill.md
Name: vga_rect_fill

Overview:
- Wishbone initiator that fills an axis-aligned rectangle of the VGA framebuffer with one colour.
- Issues one single-beat write per pixel to the VGA framebuffer slave.
- Sits between a command source (CPU or test logic) and the VGA block's Wishbone port.
- Clips rectangles to the screen and reports completion and bus errors.

Parameters:
- VGA_WIDTH, 640: pixels per row.
- VGA_HEIGHT, 480: rows.
- VGA_COLOR_DEPTH, 8: bits per channel. 3*VGA_COLOR_DEPTH must be ≤ 32; elaboration error otherwise.
- BASE_ADDR, 32'h0000_0000: byte address of pixel (0,0).
- ACK_TIMEOUT, 255: maximum cycles to wait for ack_i before aborting.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine idle, command accepted when cmd_valid is also high
- cmd_x  in  10  left column
- cmd_y  in  9  top row
- cmd_w  in  10  width in pixels
- cmd_h  in  10  height in pixels
- cmd_color  in  3*VGA_COLOR_DEPTH  packed {r,g,b}, r in the MSBs
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of every accepted command
- err  out  1  sticky ack timeout flag
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe
- we_o  out  1  write enable (always 1 when stb_o is high)
- sel_o  out  4  byte select, 4'hF during a write
- addr_o  out  32  byte address
- data_o  out  32  write data
- ack_i  in  1  slave acknowledge

Behaviour:
- Reset, sampled on clk rising edge:
  - state=IDLE.
  - cyc_o, stb_o, we_o, done, err = 0.
  - sel_o, addr_o, data_o = 0.
  - cmd_ready=0 while rst is high; it goes to 1 in the first cycle after rst falls.
  - An in-flight transaction is abandoned; ack_i is ignored while rst is high.
- States: IDLE, CLIP, WRITE, NEXT, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch all cmd_* fields, clear err, go to CLIP.
- CLIP (1 cycle):
  - If cmd_x ≥ VGA_WIDTH, cmd_y ≥ VGA_HEIGHT, cmd_w==0 or cmd_h==0: go to DONE. No bus activity.
  - Otherwise:
    - x_last = min(cmd_x+cmd_w, VGA_WIDTH)-1.
    - y_last = min(cmd_y+cmd_h, VGA_HEIGHT)-1.
    - Sums use 11-bit arithmetic; no wrap.
  - Load cx=cmd_x, cy=cmd_y.
  - Load row_addr = addr_o = BASE_ADDR + 4*(cmd_y*VGA_WIDTH + cmd_x), computed in 32 bits.
  - Go to WRITE.
- WRITE:
  - cyc_o=stb_o=we_o=1, sel_o=4'hF.
  - data_o = zero-extended cmd_color.
  - addr_o and data_o stay stable until ack_i is sampled high.
  - A timeout counter increments each cycle in WRITE.
  - ack_i high: go to NEXT.
  - Counter reaches ACK_TIMEOUT with no ack: set err, go to DONE.
- NEXT (1 cycle):
  - cyc_o=stb_o=we_o=0, sel_o=0.
  - If cx==x_last && cy==y_last: go to DONE.
  - Else if cx==x_last: cx=cmd_x, cy++, row_addr += 4*VGA_WIDTH, addr_o = new row_addr.
  - Else: cx++, addr_o += 4.
  - Then go to WRITE.
- Traversal order is row-major: x increasing, then y increasing.
- DONE: done=1 for exactly one cycle, then IDLE. busy falls in the same cycle cmd_ready rises.
- Timing:
  - Zero-latency slave (ack_i comb with stb_o): 2 cycles per pixel.
  - Registered ack: 3 cycles per pixel.
- ack_i outside WRITE is ignored. cmd_valid while busy is ignored and not queued.
- err holds until the next accepted command or reset.

Test Plan:
1. Basic fill:
   - Stimulus: x=10, y=5, w=2, h=2, color=24'hFF0000; slave acks 1 cycle after stb.
   - Required: 4 writes, addr 0x3228, 0x322C, 0x3C28, 0x3C2C; data_o=0x00FF0000; sel_o=4'hF; exactly one done pulse; err=0.
2. Clipping:
   - Stimulus: x=638, y=479, w=5, h=5.
   - Required: exactly 2 writes, addr 0x12BFF8 then 0x12BFFC; done once.
3. Degenerate commands:
   - Stimulus: x=640, then w=0, then h=0.
   - Required: cyc_o never asserted; done pulses 2 cycles after each accept.
4. Wait states:
   - Stimulus: 3x1 rect; slave delays ack 3 cycles per write.
   - Required: stb_o, addr_o, data_o stable throughout each wait; 3 writes at consecutive +4 addresses.
5. Timeout:
   - Stimulus: ACK_TIMEOUT=15, slave never acks.
   - Required: stb_o drops after 15 WRITE cycles; err=1; one done pulse.
   - Follow-up: next accepted command clears err.
6. Reset mid-fill:
   - Stimulus: assert rst for 1 cycle after the 2nd ack of a 4x4 fill.
   - Required: cyc_o=0, busy=0 from the reset edge; no further writes; cmd_ready=1 the cycle after rst falls.
